// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add / restoring-subtract
// datapath shared by MULT, MULTU, DIV and DIVU, WIDTH iterations per operation.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted only at an edge where busy=0; done pulses for
  // one cycle after HI/LO take the result. busy and done are never both high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rsh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_CALC;
      S_CALC: if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator: multiply keeps the partial product in the upper half and shifts
  // low product bits in from the top; divide keeps remainder above dividend/quotient.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    div_rsh  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rsh - {1'b0, b_q};
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo      = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rs_d      = rs_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d = op;
          a_d  = rs_data;
          b_d  = rt_data;
          rs_d = rs_data;
        end
      end
      S_PREP: begin
        if (is_signed && a_q[WIDTH-1]) a_d = ~a_q + 1'b1;
        if (is_signed && b_q[WIDTH-1]) b_d = ~b_q + 1'b1;
        neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = is_signed & a_q[WIDTH-1];
        acc_d     = '0;
        if (is_div) acc_d[WIDTH-1:0] = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
        cnt_d     = '0;
      end
      S_CALC: begin
        if (!is_div) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end else if (!div_diff[WIDTH]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          // Divide by zero: quotient saturates to all ones, HI keeps the dividend.
          lo_d = '1;
          hi_d = rs_q;
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rs_q      <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rs_q      <= rs_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, abort/ignore
// scenarios and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_acc   = 0;

  logic [2*W-1:0] exp_q[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: count done pulses; done must never coincide with busy.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      chk("done_with_busy", {63'd0, busy}, 64'd0);
    end
  end

  // Reference model returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // mode: 0 plain, 1 extra start at E+10, 2 MTHI at E+10, 3 MTHI in the start edge
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input logic [63:0] exp);
    int n;
    int nbusy;
    int extra;
    bit seen;
    logic [31:0] hi_before;
    @(negedge clk);
    hi_before = hi;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    if (mode == 3) begin
      hi_we = 1'b1;
      wdata = 32'h1234;
    end
    exp_q.push_back(exp);
    n_acc++;
    n = 0; nbusy = 0; seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start   = 1'b0;
        hi_we   = 1'b0;
        op      = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        if (mode == 3) chk("mthi_with_start", {32'd0, hi}, 64'h1234);
      end
      if (busy) nbusy++;
      if (done) seen = 1'b1;
      if (mode == 1 && n == 10) start = 1'b1;
      if (mode == 1 && n == 11) start = 1'b0;
      if (mode == 2 && n == 10) begin
        hi_we = 1'b1;
        wdata = 32'h1234;
      end
      if (mode == 2 && n == 11) begin
        hi_we = 1'b0;
        chk("mthi_while_busy", {32'd0, hi}, {32'd0, hi_before});
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      chk("latency", 64'(n), 64'd35);
      chk("busy_cycles", 64'(nbusy), 64'd34);
      chk("result", {hi, lo}, exp_q.pop_front());
    end
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk("no_second_done", 64'(extra), 64'd0);
    end
  endtask

  logic [1:0]  d_op [7];
  logic [31:0] d_a  [7];
  logic [31:0] d_b  [7];
  logic [63:0] d_e  [7];

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    d_op[0] = 2'd0; d_a[0] = 32'hFFFF_FFFE; d_b[0] = 32'd3;          d_e[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFA};
    d_op[1] = 2'd1; d_a[1] = 32'hFFFF_FFFF; d_b[1] = 32'hFFFF_FFFF;  d_e[1] = {32'hFFFF_FFFE, 32'h0000_0001};
    d_op[2] = 2'd2; d_a[2] = 32'hFFFF_FFF9; d_b[2] = 32'd2;          d_e[2] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    d_op[3] = 2'd3; d_a[3] = 32'd7;         d_b[3] = 32'd2;          d_e[3] = {32'd1, 32'd3};
    d_op[4] = 2'd2; d_a[4] = 32'h8000_0000; d_b[4] = 32'hFFFF_FFFF;  d_e[4] = {32'd0, 32'h8000_0000};
    d_op[5] = 2'd2; d_a[5] = 32'hFFFF_FFF9; d_b[5] = 32'd0;          d_e[5] = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
    d_op[6] = 2'd3; d_a[6] = 32'd5;         d_b[6] = 32'd0;          d_e[6] = {32'd5, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(d_op[i], d_a[i], d_b[i], 0, d_e[i]);

    run_op(2'd0, 32'd12345, 32'hFFFF_FFFD, 1, model(2'd0, 32'd12345, 32'hFFFF_FFFD));
    run_op(2'd3, 32'd100, 32'd7, 2, {32'd2, 32'd14});
    run_op(2'd1, 32'd3, 32'd5, 3, {32'd0, 32'd15});

    // MTHI / MTLO while idle
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", {32'd0, hi}, 64'h1234);
    chk("mthi_no_done", {63'd0, done}, 64'd0);
    lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", {hi, lo}, {32'h1234, 32'h5678});

    // reset at E+20 of a DIV aborts it
    start = 1'b1; op = 2'd2; rs_data = 32'hFFFF_FF9C; rt_data = 32'd7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 20) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    run_op(2'd0, 32'd7, 32'hFFFF_FFFA, 0, {32'hFFFF_FFFF, 32'hFFFF_FFD6});

    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, 0, model(ro, ra, rb));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("done_per_start", 64'(n_done), 64'(n_acc));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
